// File: rtl/onehot_pkg.sv
// Shared constants and helpers for the one-hot up/down ring counter.
package onehot_pkg;

  localparam int ONEHOT_N_DEF           = 8;
  localparam int ONEHOT_RESET_INDEX_DEF = 0;

  // Width of a binary index into an n-bit one-hot vector (never below 1).
  function automatic int onehot_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// One-hot to binary encoder with a legality flag (exactly one bit set).
module onehot_encoder #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_onehot,
  output logic [IW-1:0] o_index,
  output logic          o_legal
);

  logic          w_seen;
  logic          w_multi;
  logic [IW-1:0] w_idx;

  // Scan the vector: remember whether a hot bit was seen and whether a second one followed.
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (i_onehot[i]) begin
        w_multi = w_multi | w_seen;
        w_seen  = 1'b1;
        w_idx   = w_idx | IW'(i);
      end
    end
  end

  assign o_legal = w_seen & ~w_multi;
  // An illegal vector reports index 0 rather than a meaningless OR of positions.
  assign o_index = o_legal ? w_idx : '0;

endmodule

// File: rtl/onehot_updown_counter.sv
// One-hot ring counter: rotates up/down, loads a position, self-recovers from illegal states.
module onehot_updown_counter
  import onehot_pkg::*;
#(
  parameter  int N           = ONEHOT_N_DEF,
  parameter  int RESET_INDEX = ONEHOT_RESET_INDEX_DEF,
  localparam int IW          = onehot_idx_w(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          up,
  input  logic          load,
  input  logic [IW-1:0] load_index,
  output logic [N-1:0]  q,
  output logic [IW-1:0] index,
  output logic          tc,
  output logic          error
);

  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] RST_HOT = ONE << RESET_INDEX;

  logic [N-1:0]  r_q;
  logic          r_error;

  logic          w_legal;
  logic [IW-1:0] w_index;
  logic          w_load_ok;
  logic [N-1:0]  w_load_hot;
  logic [N-1:0]  w_rot_up;
  logic [N-1:0]  w_rot_dn;
  logic [N-1:0]  w_q_nxt;
  logic          w_err_nxt;

  onehot_encoder #(
    .N  (N),
    .IW (IW)
  ) u_enc (
    .i_onehot (r_q),
    .o_index  (w_index),
    .o_legal  (w_legal)
  );

  // Only reachable when N is not a power of two; such loads are rejected.
  assign w_load_ok  = (32'(load_index) < N);
  assign w_load_hot = ONE << load_index;
  assign w_rot_up   = {r_q[N-2:0], r_q[N-1]};
  assign w_rot_dn   = {r_q[0], r_q[N-1:1]};

  // Next state: illegal recovery beats load, load beats enable, otherwise hold.
  always_comb begin
    w_q_nxt   = r_q;
    w_err_nxt = 1'b0;
    if (!w_legal) begin
      w_q_nxt   = RST_HOT;
      w_err_nxt = 1'b1;
    end else if (load) begin
      if (w_load_ok) w_q_nxt   = w_load_hot;
      else           w_err_nxt = 1'b1;
    end else if (enable) begin
      w_q_nxt = up ? w_rot_up : w_rot_dn;
    end
  end

  // State register; synchronous reset discards any pending load or advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q     <= RST_HOT;
      r_error <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_error <= w_err_nxt;
    end
  end

  // Terminal count marks the edge on which an advance wraps around the ring.
  assign tc    = enable & ~load & w_legal & ((up & r_q[N-1]) | (~up & r_q[0]));
  assign q     = r_q;
  assign index = w_index;
  assign error = r_error;

endmodule

// File: tb/tb_onehot_updown_counter.sv
// Directed bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_onehot_updown_counter;

  localparam int D4  = 0;  // N=4, RESET_INDEX=0
  localparam int D4R = 1;  // N=4, RESET_INDEX=2
  localparam int D6  = 2;  // N=6
  localparam int D3  = 3;  // N=3

  logic clock = 1'b0;
  logic reset, enable, up, load;
  logic [1:0] li4, li3;
  logic [2:0] li6;

  logic [3:0] q4, q4r;
  logic [1:0] idx4, idx4r;
  logic       tc4, er4, tc4r, er4r;
  logic [5:0] q6;
  logic [2:0] idx6;
  logic       tc6, er6;
  logic [2:0] q3;
  logic [1:0] idx3;
  logic       tc3, er3;

  always #5 clock = ~clock;

  onehot_updown_counter #(.N(4), .RESET_INDEX(0)) u4 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_index(li4), .q(q4), .index(idx4), .tc(tc4), .error(er4));

  onehot_updown_counter #(.N(4), .RESET_INDEX(2)) u4r (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_index(li4), .q(q4r), .index(idx4r), .tc(tc4r), .error(er4r));

  onehot_updown_counter #(.N(6), .RESET_INDEX(0)) u6 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_index(li6), .q(q6), .index(idx6), .tc(tc6), .error(er6));

  onehot_updown_counter #(.N(3), .RESET_INDEX(0)) u3 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_index(li3), .q(q3), .index(idx3), .tc(tc3), .error(er3));

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] q;
    logic [7:0] idx;
    logic       tc;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
  endtask

  // Drive one cycle of inputs and queue what the selected DUT must show during it.
  task automatic step(input int dut, input bit rst, input bit en, input bit upv, input bit ld,
                      input int li, input logic [7:0] eq, input int ei, input bit etc,
                      input bit eer, input bit chk, input bit frc, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    reset  = rst;
    enable = en;
    up     = upv;
    load   = ld;
    li4    = 2'(li);
    li3    = 2'(li);
    li6    = 3'(li);
    if (frc) force u4.r_q = 4'b0110;
    if (chk) begin
      e.name = nm; e.dut = dut; e.q = eq; e.idx = 8'(ei); e.tc = etc; e.err = eer;
      sb.push_back(e);
    end
    if (frc) begin
      @(negedge clock);
      #1;
      release u4.r_q;
    end
  endtask

  // Monitor: every cycle the DUT presents a new output, pop and compare.
  initial begin
    exp_t       e;
    logic [7:0] aq, ai;
    logic       at, ae;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.dut)
          D4:      begin aq = {4'b0, q4};  ai = {6'b0, idx4};  at = tc4;  ae = er4;  end
          D4R:     begin aq = {4'b0, q4r}; ai = {6'b0, idx4r}; at = tc4r; ae = er4r; end
          D6:      begin aq = {2'b0, q6};  ai = {5'b0, idx6};  at = tc6;  ae = er6;  end
          default: begin aq = {5'b0, q3};  ai = {6'b0, idx3};  at = tc3;  ae = er3;  end
        endcase
        cmp(e.name, "q",     aq,        e.q);
        cmp(e.name, "index", ai,        e.idx);
        cmp(e.name, "tc",    {7'b0, at}, {7'b0, e.tc});
        cmp(e.name, "error", {7'b0, ae}, {7'b0, e.err});
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b0; load = 1'b0;
    li4 = '0; li3 = '0; li6 = '0;
    repeat (2) @(posedge clock);

    // N=4 rotate up through the wrap
    step(D4, 0,1,1,0,0, 8'h01,0,0,0, 1,0, "rst_up0");
    step(D4, 0,1,1,0,0, 8'h02,1,0,0, 1,0, "up1");
    step(D4, 0,1,1,0,0, 8'h04,2,0,0, 1,0, "up2");
    step(D4, 0,1,1,0,0, 8'h08,3,1,0, 1,0, "up_wrap");
    step(D4, 0,1,1,0,0, 8'h01,0,0,0, 1,0, "up4");
    // rotate down through the wrap
    step(D4, 0,1,0,0,0, 8'h02,1,0,0, 1,0, "dn0");
    step(D4, 0,1,0,0,0, 8'h01,0,1,0, 1,0, "dn_wrap");
    step(D4, 0,1,0,0,0, 8'h08,3,0,0, 1,0, "dn2");
    step(D4, 0,0,0,0,0, 8'h04,2,0,0, 1,0, "hold0");
    step(D4, 0,0,1,0,0, 8'h04,2,0,0, 1,0, "hold1");
    // load wins over enable
    step(D4, 0,1,1,1,1, 8'h04,2,0,0, 1,0, "ld1_en");
    step(D4, 0,1,0,1,2, 8'h02,1,0,0, 1,0, "ld2_en");
    step(D4, 0,1,1,0,0, 8'h04,2,0,0, 1,0, "after_ld");
    step(D4, 0,1,1,1,0, 8'h08,3,0,0, 1,0, "ld_kills_tc");
    step(D4, 0,0,0,0,0, 8'h01,0,0,0, 1,0, "ld0_res");
    // illegal state recovery
    step(D4, 0,1,1,1,2, 8'h06,0,0,0, 1,1, "illegal");
    step(D4, 0,0,0,0,0, 8'h01,0,0,1, 1,0, "recover");
    step(D4, 0,0,0,0,0, 8'h01,0,0,0, 1,0, "err_clear");
    // reset overrides pending load and advance
    step(D4, 0,0,0,1,2, 8'h01,0,0,0, 1,0, "pre_rst");
    step(D4, 1,1,1,1,1, 8'h04,2,0,0, 1,0, "rst_ld_en");
    step(D4, 0,0,0,0,0, 8'h01,0,0,0, 1,0, "post_rst");

    // N=4, RESET_INDEX=2
    step(D4R,1,0,0,0,0, 8'h00,0,0,0, 0,0, "r2_rst");
    step(D4R,1,1,1,1,1, 8'h04,2,0,0, 1,0, "r2_rst_ld");
    step(D4R,0,1,1,0,0, 8'h04,2,0,0, 1,0, "r2_up0");
    step(D4R,0,1,1,0,0, 8'h08,3,1,0, 1,0, "r2_wrap");
    step(D4R,1,1,1,1,0, 8'h01,0,0,0, 1,0, "r2_rst2");
    step(D4R,0,0,0,0,0, 8'h04,2,0,0, 1,0, "r2_post");

    // N=6 bad load
    step(D6, 1,0,0,0,0, 8'h00,0,0,0, 0,0, "n6_rst");
    step(D6, 0,1,0,1,5, 8'h01,0,0,0, 1,0, "n6_ld5");
    step(D6, 0,1,1,1,7, 8'h20,5,0,0, 1,0, "n6_ld7");
    step(D6, 0,0,0,0,0, 8'h20,5,0,1, 1,0, "n6_bad");
    step(D6, 0,1,1,0,0, 8'h20,5,1,0, 1,0, "n6_wrap");
    step(D6, 0,0,0,1,6, 8'h01,0,0,0, 1,0, "n6_ld6");
    step(D6, 0,0,0,0,0, 8'h01,0,0,1, 1,0, "n6_bad2");

    // N=3 with up toggled every cycle
    step(D3, 1,0,0,0,0, 8'h00,0,0,0, 0,0, "n3_rst");
    step(D3, 0,1,1,0,0, 8'h01,0,0,0, 1,0, "n3_t0");
    step(D3, 0,1,0,0,0, 8'h02,1,0,0, 1,0, "n3_t1");
    step(D3, 0,1,1,0,0, 8'h01,0,0,0, 1,0, "n3_t2");
    step(D3, 0,1,0,0,0, 8'h02,1,0,0, 1,0, "n3_t3");
    step(D3, 0,1,0,0,0, 8'h01,0,1,0, 1,0, "n3_dnwrap");
    step(D3, 0,0,0,1,3, 8'h04,2,0,0, 1,0, "n3_ld3");
    step(D3, 0,0,0,0,0, 8'h04,2,0,1, 1,0, "n3_bad");

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clock);
    #1;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
